// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared states, opcodes, mux codes and per-state control decode for the multicycle controller
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // fetch marks the state whose ir_write/pc_update follow mem_ready
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       fetch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_state(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_src_of(logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller-to-datapath bundle: instruction fields, flags and control outputs
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       imm_src;
  logic             reg_write;
  logic [2:0]       alu_control;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alu_control, illegal, instret
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alu_control, illegal, instret
  );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp, funct3, op[5] and funct7b5 to the ALU operation code
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // funct7b5 only means sub for register-register ops; addi ignores it
          3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I-subset controller: sequencing FSM, registered control, retire counter
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB, S_BEQ: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JAL:   state_d = S_ALUWB;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    // outputs are decoded from the next state so they register in step with it
    ctrl_d = decode_state(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_state(S_FETCH);
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      instret_q <= instret_d;
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (bus.funct3),
    .op_b5       (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.alu_control)
  );

  // enables are gated by rst so nothing writes between rst rising and the flops clearing
  assign bus.ir_write   = ~rst & ctrl_q.fetch & bus.mem_ready;
  assign bus.pc_write   = ~rst & ((ctrl_q.fetch & bus.mem_ready) | ctrl_q.pc_update |
                                  (ctrl_q.branch & bus.zero));
  assign bus.mem_write  = ~rst & ctrl_q.mem_write;
  assign bus.reg_write  = ~rst & ctrl_q.reg_write;
  assign bus.illegal    = ~rst & ctrl_q.illegal;
  assign bus.adr_src    = ctrl_q.adr_src;
  assign bus.result_src = ctrl_q.result_src;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.imm_src    = imm_src_of(bus.op);
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized instruction-level check of multicycle_control against a step-list model
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       wt;
    logic       fetch;
    logic       adr;
    logic       mw;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] kind;
    logic       rw;
    logic       pcu;
    logic       br;
    logic       ill;
  } step_t;

  localparam step_t T_FETCH = '{wt:1, fetch:1, adr:0, mw:0, res:2, a:0, b:2, kind:0, rw:0, pcu:0, br:0, ill:0};
  localparam step_t T_DEC   = '{wt:0, fetch:0, adr:0, mw:0, res:0, a:1, b:1, kind:0, rw:0, pcu:0, br:0, ill:0};
  localparam step_t T_MADR  = '{wt:0, fetch:0, adr:0, mw:0, res:0, a:2, b:1, kind:0, rw:0, pcu:0, br:0, ill:0};
  localparam step_t T_MRD   = '{wt:1, fetch:0, adr:1, mw:0, res:0, a:0, b:0, kind:0, rw:0, pcu:0, br:0, ill:0};
  localparam step_t T_MWB   = '{wt:0, fetch:0, adr:0, mw:0, res:1, a:0, b:0, kind:0, rw:1, pcu:0, br:0, ill:0};
  localparam step_t T_MWR   = '{wt:1, fetch:0, adr:1, mw:1, res:0, a:0, b:0, kind:0, rw:0, pcu:0, br:0, ill:0};
  localparam step_t T_EXR   = '{wt:0, fetch:0, adr:0, mw:0, res:0, a:2, b:0, kind:2, rw:0, pcu:0, br:0, ill:0};
  localparam step_t T_EXI   = '{wt:0, fetch:0, adr:0, mw:0, res:0, a:2, b:1, kind:2, rw:0, pcu:0, br:0, ill:0};
  localparam step_t T_AWB   = '{wt:0, fetch:0, adr:0, mw:0, res:0, a:0, b:0, kind:0, rw:1, pcu:0, br:0, ill:0};
  localparam step_t T_BEQ   = '{wt:0, fetch:0, adr:0, mw:0, res:0, a:2, b:0, kind:1, rw:0, pcu:0, br:1, ill:0};
  localparam step_t T_JAL   = '{wt:0, fetch:0, adr:0, mw:0, res:0, a:1, b:2, kind:0, rw:0, pcu:1, br:0, ill:0};
  localparam step_t T_TRAP  = '{wt:0, fetch:0, adr:0, mw:0, res:0, a:0, b:0, kind:0, rw:0, pcu:0, br:0, ill:1};

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] exp_instret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] op_of(input int cls);
    logic [6:0] t [6];
    t = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    return t[cls];
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    for (int i = 0; i < 6; i++) if (o == op_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [1:0] kind, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7);
    if (kind == 2'd1) return 3'b001;
    if (kind == 2'd0) return 3'b000;
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  task automatic check_step(input step_t s);
    logic e_ir, e_pc;
    e_ir = s.fetch & bus.mem_ready;
    e_pc = e_ir | s.pcu | (s.br & bus.zero);
    chk("ir_write", bus.ir_write, e_ir);
    chk("pc_write", bus.pc_write, e_pc);
    chk("mem_write", bus.mem_write, s.mw);
    chk("reg_write", bus.reg_write, s.rw);
    chk("adr_src", bus.adr_src, s.adr);
    chk("result_src", bus.result_src, s.res);
    chk("alu_src_a", bus.alu_src_a, s.a);
    chk("alu_src_b", bus.alu_src_b, s.b);
    chk("alu_control", bus.alu_control, exp_alu(s.kind, bus.op, bus.funct3, bus.funct7b5));
    chk("imm_src", bus.imm_src, exp_imm(bus.op));
    chk("illegal", bus.illegal, s.ill);
    chk("instret", bus.instret, exp_instret);
  endtask

  // cls: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 unsupported opcode
  task automatic run_instr(input int cls, input logic [6:0] opv, input logic [2:0] f3,
                           input logic f7, input int fw, input int mwt, input logic zv,
                           input bit abort_mw, output int cyc, output int n_ir,
                           output int n_mw, output int n_rw, output int n_pc);
    step_t q[$];
    step_t s;
    int    idx, wc, need, trap_n;
    bit    done;
    q = '{T_FETCH, T_DEC};
    case (cls)
      0: q = {q, T_MADR, T_MRD, T_MWB};
      1: q = {q, T_MADR, T_MWR};
      2: q = {q, T_EXR, T_AWB};
      3: q = {q, T_EXI, T_AWB};
      4: q = {q, T_BEQ};
      5: q = {q, T_JAL, T_AWB};
      default: q = {q, T_TRAP};
    endcase
    idx = 0; wc = 0; trap_n = 0; done = 0;
    cyc = 0; n_ir = 0; n_mw = 0; n_rw = 0; n_pc = 0;
    bus.op = opv; bus.funct3 = f3; bus.funct7b5 = f7;
    while (!done) begin
      s = q[idx];
      need = (idx == 0) ? fw : mwt;
      bus.mem_ready = s.wt ? (wc >= need) : 1'($urandom);
      bus.zero      = s.br ? zv : 1'($urandom);
      @(negedge clk);
      check_step(s);
      cyc++;
      n_ir += int'(bus.ir_write);
      n_mw += int'(bus.mem_write);
      n_rw += int'(bus.reg_write);
      n_pc += int'(bus.pc_write);
      if (abort_mw && s.mw && wc == 1) begin
        #1 rst = 1'b1;
        #1;
        chk("abort_mem_write", bus.mem_write, 0);
        chk("abort_instret", bus.instret, 0);
        exp_instret = 0;
        done = 1;
      end else if (s.ill && trap_n >= 5) begin
        chk("trap_illegal_sticky", bus.illegal, 1);
        done = 1;
      end else if (cyc > 300) begin
        chk("cycle_budget", cyc, 0);
        done = 1;
      end else begin
        @(posedge clk);
        if (s.ill) trap_n++;
        else if (!s.wt || bus.mem_ready) begin
          idx++;
          wc = 0;
        end else wc++;
        if (idx == q.size()) begin
          exp_instret++;
          done = 1;
        end
        #1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b1;
    bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_write", bus.pc_write, 0);
    chk("rst_ir_write", bus.ir_write, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_instret", bus.instret, 0);
    rst = 1'b0;
    exp_instret = 0;
  endtask

  initial begin
    int cyc, n_ir, n_mw, n_rw, n_pc, cls;
    logic [6:0] bad;
    do_reset();

    run_instr(2, op_of(2), 3'b000, 1'b0, 0, 0, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("add_cycles", cyc, 4);
    chk("add_instret", bus.instret, 1);
    chk("add_reg_write", n_rw, 1);
    run_instr(2, op_of(2), 3'b000, 1'b1, 0, 0, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("sub_cycles", cyc, 4);
    run_instr(3, op_of(3), 3'b000, 1'b1, 0, 0, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("addi_cycles", cyc, 4);
    run_instr(0, op_of(0), 3'b010, 1'b0, 2, 3, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("lw_cycles", cyc, 10);
    chk("lw_ir_pulses", n_ir, 1);
    chk("lw_reg_write", n_rw, 1);
    run_instr(1, op_of(1), 3'b010, 1'b0, 0, 2, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("sw_mem_write_cycles", n_mw, 3);
    chk("sw_reg_write", n_rw, 0);
    chk("sw_cycles", cyc, 6);
    run_instr(4, op_of(4), 3'b000, 1'b0, 0, 0, 1'b1, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("beq_taken_cycles", cyc, 3);
    chk("beq_taken_pc_writes", n_pc, 2);
    run_instr(4, op_of(4), 3'b000, 1'b0, 0, 0, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("beq_not_taken_pc_writes", n_pc, 1);
    run_instr(5, op_of(5), 3'b000, 1'b0, 0, 0, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("jal_cycles", cyc, 4);
    chk("jal_pc_writes", n_pc, 2);
    chk("jal_reg_write", n_rw, 1);
    chk("directed_instret", bus.instret, 8);

    for (int i = 0; i < 150; i++) begin
      cls = $urandom_range(0, 5);
      run_instr(cls, op_of(cls), 3'($urandom), 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom), 0, cyc, n_ir, n_mw, n_rw, n_pc);
    end

    run_instr(6, 7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("trap_instret_frozen", bus.instret, exp_instret);
    do_reset();

    run_instr(1, op_of(1), 3'b000, 1'b0, 0, 4, 1'b0, 1, cyc, n_ir, n_mw, n_rw, n_pc);
    do_reset();
    run_instr(2, op_of(2), 3'b111, 1'b0, 0, 0, 1'b0, 0, cyc, n_ir, n_mw, n_rw, n_pc);
    chk("post_abort_instret", bus.instret, 1);

    for (int i = 0; i < 4; i++) begin
      do bad = 7'($urandom); while (is_legal(bad));
      run_instr(6, bad, 3'($urandom), 1'($urandom), $urandom_range(0, 2), 0, 1'b0, 0,
                cyc, n_ir, n_mw, n_rw, n_pc);
      do_reset();
      for (int j = 0; j < 20; j++) begin
        cls = $urandom_range(0, 5);
        run_instr(cls, op_of(cls), 3'($urandom), 1'($urandom), $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'($urandom), 0, cyc, n_ir, n_mw, n_rw, n_pc);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle controller FSM that sequences the shared datapath for the RV32I subset: lw, sw, R-type, I-type ALU, beq, jal.
- One memory port carries both instruction fetch and data access, selected by adr_src.
- The block generates every mux select and write enable, honours a memory ready handshake, counts retired instructions, and traps on unsupported opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  Instr[6:0].
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction-register and OldPC enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1 data.
- alu_src_b  out  2  ALU B mux: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  out  1  register-file write enable.
- alu_control  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- illegal  out  1  sticky trap flag.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset:
  - Async rst forces state to FETCH and instret to 0.
  - While rst = 1, pc_write, ir_write, mem_write and reg_write are forced to 0, and illegal = 0.
- Outputs are Moore-decoded from the state register, with three exceptions:
  - imm_src is decoded from op in every state: lw/I-type = 00, sw = 01, beq = 10, jal = 11, other = 00.
  - alu_control comes from ALUOp and funct3.
  - pc_write = pc_update | (branch & zero).
- ALU decoder:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 decodes funct3: 000 gives sub if op[5] & funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- Any signal not listed for a state below is 0.
- FETCH:
  - Outputs: adr_src = 0, A = 00, B = 10, ALUOp = 00, result_src = 10; ir_write = pc_update = mem_ready.
  - Next: stay in FETCH until mem_ready, then DECODE.
- DECODE:
  - Outputs: A = 01, B = 01, ALUOp = 00 (precomputes the branch target).
  - Next by op: lw/sw -> MEMADR; R -> EXECR; I -> EXECI; beq -> BEQ; jal -> JAL; any other op -> TRAP.
- MEMADR:
  - Outputs: A = 10, B = 01, ALUOp = 00.
  - Next: lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD:
  - Outputs: adr_src = 1, result_src = 00.
  - Next: hold until mem_ready, then MEMWB.
- MEMWB:
  - Outputs: result_src = 01, reg_write = 1.
  - Next: FETCH.
- MEMWRITE:
  - Outputs: adr_src = 1, result_src = 00; mem_write = 1 held every cycle until mem_ready.
  - Next: FETCH once mem_ready.
- EXECR:
  - Outputs: A = 10, B = 00, ALUOp = 10.
  - Next: ALUWB.
- EXECI:
  - Outputs: A = 10, B = 01, ALUOp = 10.
  - Next: ALUWB.
- ALUWB:
  - Outputs: result_src = 00, reg_write = 1.
  - Next: FETCH.
- BEQ:
  - Outputs: A = 10, B = 00, ALUOp = 01, result_src = 00, branch = 1.
  - Next: FETCH.
- JAL:
  - Outputs: A = 01, B = 10, ALUOp = 00, result_src = 00, pc_update = 1.
  - Next: ALUWB, which writes PC+4 to rd.
- TRAP:
  - Outputs: all enables 0, illegal = 1.
  - Next: stays in TRAP until rst.
- Latency with mem_ready tied high: lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles. Each wait cycle adds 1.
- instret:
  - Increments by 1 on each transition to FETCH from MEMWB, MEMWRITE (ready), ALUWB or BEQ.
  - Wraps modulo 2^CNT_W; frozen in TRAP.
- rst asserted mid-instruction aborts the instruction immediately; no partial write occurs after rst rises.

Decomposition:
- Shared package (rv_ctrl_pkg) holds:
  - state enum;
  - opcode constants (LW 0000011, SW 0100011, R 0110011, I 0010011, BEQ 1100011, JAL 1101111);
  - ALUOp codes, alu_control codes, and the result_src, alu_src_a, alu_src_b and imm_src codes.
- Sub-module alu_decoder: combinational mapping of ALUOp, funct3, op[5] and funct7b5 to alu_control.

Test Plan:
- add (op 0110011, funct3 000, funct7b5 0), mem_ready = 1 -> states FETCH, DECODE, EXECR, ALUWB; alu_control 000 in EXECR; reg_write = 1 in cycle 4; instret 0 -> 1.
- sub (funct7b5 1), then addi (op 0010011, funct7b5 1) -> alu_control 001 for sub, 000 for addi.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD -> ir_write pulses once; 10 cycles total; reg_write with result_src 01 in the last cycle.
- sw with mem_ready low for 2 cycles in MEMWRITE -> mem_write = 1 for 3 consecutive cycles, adr_src = 1; reg_write never asserted.
- beq with zero = 1, then beq with zero = 0 -> pc_write = 1 in BEQ only when zero = 1; each beq takes 3 cycles; jal asserts pc_write in JAL and reg_write in ALUWB.
- op 1111111 -> TRAP; illegal = 1 and instret frozen; async rst mid-MEMWRITE -> mem_write drops within the same cycle, state FETCH, instret = 0.
